// File: rtl/btb_predictor_if.sv
// rtl/btb_predictor_if.sv - fetch lookup, prediction and resolve-update signal bundle for btb_predictor
interface btb_predictor_if #(
   parameter int PC_W = 64
);
   logic            en;
   logic [PC_W-1:0] lookup_pc;
   logic            pred_hit;
   logic            pred_taken;
   logic [PC_W-1:0] pred_target;
   logic            upd_valid;
   logic [PC_W-1:0] upd_pc;
   logic [PC_W-1:0] upd_target;
   logic            upd_taken;
   logic            upd_jump;

   modport master (
      output en,
      output lookup_pc,
      output upd_valid,
      output upd_pc,
      output upd_target,
      output upd_taken,
      output upd_jump,
      input  pred_hit,
      input  pred_taken,
      input  pred_target
   );

   modport slave (
      input  en,
      input  lookup_pc,
      input  upd_valid,
      input  upd_pc,
      input  upd_target,
      input  upd_taken,
      input  upd_jump,
      output pred_hit,
      output pred_taken,
      output pred_target
   );
endinterface

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped BTB with 2-bit direction counters; optional macro BTB_BYPASS_EN
module btb_predictor #(
   parameter int PC_W    = 64,
   parameter int ENTRIES = 8,
   parameter int IDX_LSB = 2
) (
   input logic            clk,
   input logic            arst_n,
   btb_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_LSB - IDX_W;

   // Table storage: only the valid bits are reset, payload is don't-care until valid.
   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] jmp_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [PC_W-1:0]    target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];

   // Index/tag split, identical for the lookup and update ports.
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;

   assign lk_idx = bus.lookup_pc[IDX_LSB +: IDX_W];
   assign lk_tag = bus.lookup_pc[PC_W-1 -: TAG_W];
   assign up_idx = bus.upd_pc[IDX_LSB +: IDX_W];
   assign up_tag = bus.upd_pc[PC_W-1 -: TAG_W];

   // Alignment bits below IDX_LSB never take part in indexing or tagging.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.lookup_pc, bus.upd_pc};

   // Resolve-stage write decision and the new contents of the addressed row.
   logic             up_hit;
   logic             up_tk;
   logic             wr_en;
   logic [TAG_W-1:0] nxt_tag;
   logic [PC_W-1:0]  nxt_target;
   logic [1:0]       nxt_ctr;
   logic             nxt_jmp;

   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign up_tk  = bus.upd_taken | bus.upd_jump;

   // Compute the post-update row; not-taken misses never allocate.
   always_comb begin
      wr_en      = 1'b0;
      nxt_tag    = up_tag;
      nxt_target = target_q[up_idx];
      nxt_ctr    = ctr_q[up_idx];
      nxt_jmp    = jmp_q[up_idx];
      if (bus.upd_valid) begin
         if (up_hit) begin
            wr_en = 1'b1;
            if (bus.upd_jump) begin
               nxt_target = bus.upd_target;
               nxt_jmp    = 1'b1;
               nxt_ctr    = 2'd3;
            end else if (bus.upd_taken) begin
               nxt_target = bus.upd_target;
               nxt_jmp    = 1'b0;
               nxt_ctr    = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
            end else begin
               nxt_ctr    = (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
            end
         end else if (up_tk) begin
            wr_en      = 1'b1;
            nxt_target = bus.upd_target;
            nxt_jmp    = bus.upd_jump;
            nxt_ctr    = bus.upd_jump ? 2'd3 : 2'd2;
         end
      end
   end

   // Valid bits: cleared by reset, set whenever a row is written.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         valid_q <= '0;
      end else if (bus.en && wr_en) begin
         valid_q[up_idx] <= 1'b1;
      end
   end

   // Row payload write; suppressed while reset is asserted so reset wins over updates.
   always_ff @(posedge clk) begin
      if (arst_n && bus.en && wr_en) begin
         tag_q[up_idx]    <= nxt_tag;
         target_q[up_idx] <= nxt_target;
         ctr_q[up_idx]    <= nxt_ctr;
         jmp_q[up_idx]    <= nxt_jmp;
      end
   end

   // Lookup read: table contents before this cycle's write, or forwarded row when bypassing.
   logic            lk_hit;
   logic            lk_ctr_hi;
   logic            lk_jmp;
   logic [PC_W-1:0] lk_target_raw;
   logic            lk_taken;
   logic [PC_W-1:0] lk_target;

`ifdef BTB_BYPASS_EN
   logic fwd;
   assign fwd = bus.upd_valid && (bus.upd_pc == bus.lookup_pc);
`endif

   // Select the row seen by the lookup; a same-PC update with no write stays a miss.
   always_comb begin
      lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_ctr_hi     = ctr_q[lk_idx][1];
      lk_jmp        = jmp_q[lk_idx];
      lk_target_raw = target_q[lk_idx];
`ifdef BTB_BYPASS_EN
      if (fwd && wr_en) begin
         lk_hit        = 1'b1;
         lk_ctr_hi     = nxt_ctr[1];
         lk_jmp        = nxt_jmp;
         lk_target_raw = nxt_target;
      end
`endif
   end

   assign lk_taken  = lk_hit & (lk_jmp | lk_ctr_hi);
   assign lk_target = lk_taken ? lk_target_raw : '0;

   logic            pred_hit_q;
   logic            pred_taken_q;
   logic [PC_W-1:0] pred_target_q;

   // Prediction register: one-cycle lookup latency, held while disabled.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         pred_hit_q    <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
      end else if (bus.en) begin
         pred_hit_q    <= lk_hit;
         pred_taken_q  <= lk_taken;
         pred_target_q <= lk_target;
      end
   end

   assign bus.pred_hit    = pred_hit_q;
   assign bus.pred_taken  = pred_taken_q;
   assign bus.pred_target = pred_target_q;

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - scoreboard bench for btb_predictor (ENTRIES=8, IDX_LSB=2, PC_W=64)
module tb_btb_predictor;
   localparam int PC_W = 64;

   logic clk = 1'b0;
   logic arst_n;

   btb_predictor_if #(.PC_W(PC_W)) bus ();

   btb_predictor #(.PC_W(PC_W), .ENTRIES(8), .IDX_LSB(2)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic [63:0] lk;
      logic        uv;
      logic [63:0] upc;
      logic [63:0] utgt;
      logic        utk;
      logic        ujmp;
      logic        eh;
      logic        et;
      logic [63:0] etgt;
   } stim_t;

   typedef struct {
      logic        h;
      logic        t;
      logic [63:0] tgt;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   function automatic stim_t mk(input logic rst_n, input logic en, input logic [63:0] lk,
                                input logic uv, input logic [63:0] upc, input logic [63:0] utgt,
                                input logic utk, input logic ujmp,
                                input logic eh, input logic et, input logic [63:0] etgt);
      stim_t s;
      s.rst_n = rst_n; s.en = en; s.lk = lk;
      s.uv = uv; s.upc = upc; s.utgt = utgt; s.utk = utk; s.ujmp = ujmp;
      s.eh = eh; s.et = et; s.etgt = etgt;
      return s;
   endfunction

   // plain lookup, no update
   function automatic stim_t lk(input logic [63:0] pc, input logic eh, input logic et, input logic [63:0] etgt);
      return mk(1'b1, 1'b1, pc, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, eh, et, etgt);
   endfunction

   // update only; lookup parked on pc 0, which is never trained
   function automatic stim_t up(input logic [63:0] pc, input logic [63:0] tgt, input logic tk, input logic jmp);
      return mk(1'b1, 1'b1, 64'h0, 1'b1, pc, tgt, tk, jmp, 1'b0, 1'b0, 64'h0);
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      arst_n         = s.rst_n;
      bus.en         = s.en;
      bus.lookup_pc  = s.lk;
      bus.upd_valid  = s.uv;
      bus.upd_pc     = s.upc;
      bus.upd_target = s.utgt;
      bus.upd_taken  = s.utk;
      bus.upd_jump   = s.ujmp;
      e.h = s.eh; e.t = s.et; e.tgt = s.etgt;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(1'b0, 1'b1, 64'h1000, 1'b1, 64'h1000, 64'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0));
      t.push_back(mk(1'b0, 1'b1, 64'h1000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0));
      t.push_back(lk(64'h1000, 1'b0, 1'b0, 64'h0));
      foreach (t[i]) begin
         step(t[i]);
         e = sb.pop_front();
         vectors++;
         if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e.h, e.t, e.tgt}) begin
            miscompares++;
            $display("FAIL reset[%0d]: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                     i, bus.pred_hit, bus.pred_taken, bus.pred_target, e.h, e.t, e.tgt);
         end
      end
   endtask

   task automatic test_allocate();
      stim_t t[$];
      exp_t  e;
      t.push_back(up(64'h1004, 64'h2000, 1'b1, 1'b0));
      t.push_back(lk(64'h1004, 1'b1, 1'b1, 64'h2000));
      foreach (t[i]) begin
         step(t[i]);
         e = sb.pop_front();
         vectors++;
         if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e.h, e.t, e.tgt}) begin
            miscompares++;
            $display("FAIL allocate[%0d]: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                     i, bus.pred_hit, bus.pred_taken, bus.pred_target, e.h, e.t, e.tgt);
         end
      end
   endtask

   task automatic test_hysteresis();
      stim_t t[$];
      exp_t  e;
      t.push_back(up(64'h1004, 64'h9999, 1'b0, 1'b0));   // ctr 2->1
      t.push_back(lk(64'h1004, 1'b1, 1'b0, 64'h0));
      t.push_back(up(64'h1004, 64'h2000, 1'b1, 1'b0));   // ->2
      t.push_back(up(64'h1004, 64'h2100, 1'b1, 1'b0));   // ->3, new target
      t.push_back(lk(64'h1004, 1'b1, 1'b1, 64'h2100));
      for (int k = 0; k < 3; k++) t.push_back(up(64'h1004, 64'h2100, 1'b1, 1'b0)); // stays 3
      t.push_back(up(64'h1004, 64'h0, 1'b0, 1'b0));      // ->2
      t.push_back(lk(64'h1004, 1'b1, 1'b1, 64'h2100));
      for (int k = 0; k < 4; k++) t.push_back(up(64'h1004, 64'h0, 1'b0, 1'b0)); // ->0 and holds
      t.push_back(lk(64'h1004, 1'b1, 1'b0, 64'h0));
      t.push_back(up(64'h1004, 64'h2200, 1'b1, 1'b0));   // ->1
      t.push_back(lk(64'h1004, 1'b1, 1'b0, 64'h0));
      t.push_back(up(64'h1004, 64'h2200, 1'b1, 1'b0));   // ->2
      t.push_back(lk(64'h1004, 1'b1, 1'b1, 64'h2200));
      foreach (t[i]) begin
         step(t[i]);
         e = sb.pop_front();
         vectors++;
         if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e.h, e.t, e.tgt}) begin
            miscompares++;
            $display("FAIL hysteresis[%0d]: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                     i, bus.pred_hit, bus.pred_taken, bus.pred_target, e.h, e.t, e.tgt);
         end
      end
   endtask

   task automatic test_jump_alias();
      stim_t t[$];
      exp_t  e;
      t.push_back(up(64'h1008, 64'h4000, 1'b0, 1'b1));   // jump alloc
      t.push_back(lk(64'h1008, 1'b1, 1'b1, 64'h4000));
      t.push_back(up(64'h1028, 64'h5000, 1'b0, 1'b0));   // alias not-taken: no write
      t.push_back(lk(64'h1008, 1'b1, 1'b1, 64'h4000));
      t.push_back(lk(64'h1028, 1'b0, 1'b0, 64'h0));
      t.push_back(up(64'h1028, 64'h5000, 1'b1, 1'b0));   // alias taken: replace
      t.push_back(lk(64'h1008, 1'b0, 1'b0, 64'h0));
      t.push_back(lk(64'h1028, 1'b1, 1'b1, 64'h5000));
      t.push_back(up(64'h1028, 64'h0, 1'b0, 1'b0));      // ctr 2->1
      t.push_back(lk(64'h1028, 1'b1, 1'b0, 64'h0));
      t.push_back(up(64'h1028, 64'h5100, 1'b0, 1'b1));   // jump hit: jmp=1 ctr=3
      t.push_back(up(64'h1028, 64'h0, 1'b0, 1'b0));      // ->2
      t.push_back(up(64'h1028, 64'h0, 1'b0, 1'b0));      // ->1, jmp keeps it taken
      t.push_back(lk(64'h1028, 1'b1, 1'b1, 64'h5100));
      t.push_back(up(64'h1028, 64'h5200, 1'b1, 1'b0));   // taken branch: jmp=0 ctr=2
      t.push_back(up(64'h1028, 64'h0, 1'b0, 1'b0));      // ->1
      t.push_back(lk(64'h1028, 1'b1, 1'b0, 64'h0));
      foreach (t[i]) begin
         step(t[i]);
         e = sb.pop_front();
         vectors++;
         if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e.h, e.t, e.tgt}) begin
            miscompares++;
            $display("FAIL jump_alias[%0d]: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                     i, bus.pred_hit, bus.pred_taken, bus.pred_target, e.h, e.t, e.tgt);
         end
      end
   endtask

   task automatic test_collision();
      stim_t t[$];
      exp_t  e;
`ifdef BTB_BYPASS_EN
      t.push_back(mk(1'b1, 1'b1, 64'h100C, 1'b1, 64'h100C, 64'h6000, 1'b1, 1'b0, 1'b1, 1'b1, 64'h6000));
`else
      t.push_back(mk(1'b1, 1'b1, 64'h100C, 1'b1, 64'h100C, 64'h6000, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0));
`endif
      t.push_back(lk(64'h100C, 1'b1, 1'b1, 64'h6000));
`ifdef BTB_BYPASS_EN
      t.push_back(mk(1'b1, 1'b1, 64'h1004, 1'b1, 64'h1004, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0));
`else
      t.push_back(mk(1'b1, 1'b1, 64'h1004, 1'b1, 64'h1004, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h2200));
`endif
      t.push_back(lk(64'h1004, 1'b1, 1'b0, 64'h0));
      t.push_back(mk(1'b1, 1'b1, 64'h1030, 1'b1, 64'h1030, 64'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0));
      t.push_back(lk(64'h1030, 1'b0, 1'b0, 64'h0));
      foreach (t[i]) begin
         step(t[i]);
         e = sb.pop_front();
         vectors++;
         if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e.h, e.t, e.tgt}) begin
            miscompares++;
            $display("FAIL collision[%0d]: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                     i, bus.pred_hit, bus.pred_taken, bus.pred_target, e.h, e.t, e.tgt);
         end
      end
   endtask

   task automatic test_enable();
      stim_t t[$];
      exp_t  e;
      t.push_back(lk(64'h100C, 1'b1, 1'b1, 64'h6000));
      t.push_back(mk(1'b1, 1'b0, 64'h1028, 1'b1, 64'h100C, 64'h0,    1'b0, 1'b0, 1'b1, 1'b1, 64'h6000));
      t.push_back(mk(1'b1, 1'b0, 64'h1028, 1'b1, 64'h1010, 64'h7000, 1'b1, 1'b0, 1'b1, 1'b1, 64'h6000));
      t.push_back(mk(1'b1, 1'b0, 64'h1028, 1'b1, 64'h100C, 64'h0,    1'b0, 1'b0, 1'b1, 1'b1, 64'h6000));
      t.push_back(lk(64'h100C, 1'b1, 1'b1, 64'h6000));
      t.push_back(lk(64'h1010, 1'b0, 1'b0, 64'h0));
      foreach (t[i]) begin
         step(t[i]);
         e = sb.pop_front();
         vectors++;
         if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e.h, e.t, e.tgt}) begin
            miscompares++;
            $display("FAIL enable[%0d]: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                     i, bus.pred_hit, bus.pred_taken, bus.pred_target, e.h, e.t, e.tgt);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t t[$];
      exp_t  e;
      t.push_back(lk(64'h1004, 1'b1, 1'b0, 64'h0));
      t.push_back(lk(64'h100C, 1'b1, 1'b1, 64'h6000));
      t.push_back(lk(64'h1028, 1'b1, 1'b0, 64'h0));
      t.push_back(lk(64'h1008, 1'b0, 1'b0, 64'h0));
      t.push_back(mk(1'b1, 1'b1, 64'h100C, 1'b1, 64'h1004, 64'h2300, 1'b1, 1'b0, 1'b1, 1'b1, 64'h6000));
      t.push_back(lk(64'h1004, 1'b1, 1'b1, 64'h2300));
      foreach (t[i]) begin
         step(t[i]);
         e = sb.pop_front();
         vectors++;
         if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e.h, e.t, e.tgt}) begin
            miscompares++;
            $display("FAIL back_to_back[%0d]: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                     i, bus.pred_hit, bus.pred_taken, bus.pred_target, e.h, e.t, e.tgt);
         end
      end
   endtask

   task automatic test_mid_reset();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(1'b0, 1'b1, 64'h100C, 1'b1, 64'h1010, 64'h7000, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0));
      t.push_back(lk(64'h1004, 1'b0, 1'b0, 64'h0));
      t.push_back(lk(64'h100C, 1'b0, 1'b0, 64'h0));
      t.push_back(lk(64'h1028, 1'b0, 1'b0, 64'h0));
      t.push_back(lk(64'h1010, 1'b0, 1'b0, 64'h0));
      t.push_back(up(64'h1004, 64'h2400, 1'b1, 1'b0));
      t.push_back(lk(64'h1004, 1'b1, 1'b1, 64'h2400));
      foreach (t[i]) begin
         step(t[i]);
         e = sb.pop_front();
         vectors++;
         if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e.h, e.t, e.tgt}) begin
            miscompares++;
            $display("FAIL mid_reset[%0d]: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                     i, bus.pred_hit, bus.pred_taken, bus.pred_target, e.h, e.t, e.tgt);
         end
      end
   endtask

   initial begin
      arst_n         = 1'b0;
      bus.en         = 1'b1;
      bus.lookup_pc  = '0;
      bus.upd_valid  = 1'b0;
      bus.upd_pc     = '0;
      bus.upd_target = '0;
      bus.upd_taken  = 1'b0;
      bus.upd_jump   = 1'b0;
      @(negedge clk);
      test_reset();
      test_allocate();
      test_hysteresis();
      test_jump_alias();
      test_collision();
      test_enable();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
